// File: rtl/lsu_core.sv
// lsu_core: single-outstanding load/store unit bridging the pipeline to a valid/ready memory port (optional misalignment check via LSU_MISALIGN_CHECK_EN)
module lsu_core #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_valid,
  output logic        ls_ready,
  input  logic        Load,
  input  logic        Loadu,
  input  logic        Store,
  input  logic [3:0]  DWHB,
  input  logic [7:0]  mask,
  input  logic [63:0] LS_addr,
  input  logic [63:0] st_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        ld_valid,
  output logic [63:0] ld_data,
  output logic        st_done,
  output logic        bus_err
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, ld_data_q, ld_data_d, sh, ext;
  logic [7:0] mask_q, mask_d;
  logic [2:0] size_q, size_d;
  logic store_q, store_d, uns_q, uns_d, err_q, err_d, capture, misal;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misal = DWHB[3] ? |LS_addr[2:0] : DWHB[2] ? |LS_addr[1:0] : DWHB[1] & LS_addr[0];
`else
  assign misal = 1'b0;
`endif
  // align the returned doubleword to the access and extend by size (D>W>H>B)
  always_comb begin
    sh = mem_rdata >> {addr_q[2:0], 3'b000};
    ext = size_q[2] ? sh :
          size_q[1] ? {{32{~uns_q & sh[31]}}, sh[31:0]} :
          size_q[0] ? {{48{~uns_q & sh[15]}}, sh[15:0]} :
                      {{56{~uns_q & sh[7]}}, sh[7:0]};
  end
  // next-state and request latching
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    mask_d = mask_q;
    size_d = size_q;
    store_d = store_q;
    uns_d = uns_q;
    err_d = err_q;
    cnt_d = cnt_q;
    ld_data_d = ld_data_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (ls_valid && (Load || Loadu || Store) && DWHB != 4'b0) begin
        addr_d = LS_addr;
        wdata_d = st_data << {LS_addr[2:0], 3'b000};
        mask_d = mask;
        size_d = DWHB[3:1];
        store_d = Store;
        uns_d = Loadu;
        err_d = misal;
        cnt_d = '0;
        state_d = misal ? RESP : REQ;
      end
      REQ: if (mem_ready) begin
        capture = ~store_q & mem_rvalid;
        state_d = (store_q || mem_rvalid) ? RESP : WAIT;
      end
      WAIT: if (mem_rvalid) begin
        capture = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WAIT_LIMIT - 1)) begin
          err_d = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) ld_data_d = ext;
  end
  // state and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      mask_q <= '0;
      size_q <= '0;
      store_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      ld_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      mask_q <= mask_d;
      size_q <= size_d;
      store_q <= store_d;
      uns_q <= uns_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      ld_data_q <= ld_data_d;
    end
  end
  assign ls_ready = state_q == IDLE;
  assign mem_valid = state_q == REQ;
  assign mem_addr = {addr_q[63:3], 3'b000};
  assign mem_wen = store_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = store_q ? mask_q : 8'h00;
  assign ld_valid = state_q == RESP && !err_q && !store_q;
  assign st_done = state_q == RESP && !err_q && store_q;
  assign bus_err = state_q == RESP && err_q;
  assign ld_data = ld_data_q;
endmodule

// File: tb/tb_lsu_core.sv
// tb_lsu_core: directed self-checking bench for lsu_core
module tb_lsu_core;
  logic clk = 0, reset = 1;
  logic ls_valid = 0, ls_ready, Load = 0, Loadu = 0, Store = 0;
  logic [3:0] DWHB = 0;
  logic [7:0] mask = 0, mem_wmask;
  logic [63:0] LS_addr = 0, st_data = 0, mem_addr, mem_wdata, mem_rdata = 0, ld_data;
  logic mem_valid, mem_ready = 0, mem_wen, mem_rvalid = 0, ld_valid, st_done, bus_err;
  int checks = 0, errors = 0;
  lsu_core dut (
    .clk(clk), .reset(reset), .ls_valid(ls_valid), .ls_ready(ls_ready),
    .Load(Load), .Loadu(Loadu), .Store(Store), .DWHB(DWHB), .mask(mask),
    .LS_addr(LS_addr), .st_data(st_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ld_valid(ld_valid), .ld_data(ld_data),
    .st_done(st_done), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic ld, input logic ldu, input logic st, input logic [3:0] sz,
                       input logic [63:0] a, input logic [7:0] m, input logic [63:0] d);
    ls_valid = 1; Load = ld; Loadu = ldu; Store = st; DWHB = sz; LS_addr = a; mask = m; st_data = d;
    step();
    ls_valid = 0; Load = 0; Loadu = 0; Store = 0;
  endtask
  task automatic run_load(input logic u, input logic [3:0] sz, input logic [63:0] a,
                          input int waits, input logic [63:0] rd);
    mem_ready = 1;
    issue(~u, u, 0, sz, a, 8'h00, 64'h0);
    if (waits == 0) begin mem_rvalid = 1; mem_rdata = rd; end
    step();
    mem_ready = 0;
    for (int i = 0; i < waits; i++) begin
      if (i == waits - 1) begin mem_rvalid = 1; mem_rdata = rd; end
      step();
    end
    mem_rvalid = 0;
  endtask
  initial begin
    int n;
    logic saw;
    step(); step();
    check("rst_ready", ls_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_wmask", mem_wmask, 0);
    check("rst_pulses", {ld_valid, st_done, bus_err}, 0);
    check("rst_ld_data", ld_data, 0);
    reset = 0;
    step();
    mem_ready = 1;
    issue(0, 0, 1, 4'b0001, 64'h8000_0003, 8'h08, 64'hAB);
    check("sb_valid", mem_valid, 1);
    check("sb_addr", mem_addr, 64'h8000_0000);
    check("sb_wmask", mem_wmask, 8'h08);
    check("sb_wdata", mem_wdata, 64'hAB00_0000);
    check("sb_wen", mem_wen, 1);
    check("sb_early", st_done, 0);
    step();
    check("sb_done", st_done, 1);
    check("sb_noload", ld_valid | bus_err, 0);
    step();
    check("sb_done_off", st_done, 0);
    check("sb_idle", ls_ready, 1);
    mem_ready = 0;
    issue(0, 0, 1, 4'b1000, 64'h8000_0010, 8'hFF, 64'h0102_0304_0506_0708);
    step(); step();
    check("sd_hold_valid", mem_valid, 1);
    check("sd_hold_wdata", mem_wdata, 64'h0102_0304_0506_0708);
    check("sd_hold_addr", mem_addr, 64'h8000_0010);
    mem_ready = 1;
    step();
    mem_ready = 0;
    check("sd_done", st_done, 1);
    step();
    run_load(0, 4'b0010, 64'h8000_0006, 3, 64'h8001_0000_0000_0000);
    check("lh_valid", ld_valid, 1);
    check("lh_data", ld_data, 64'hFFFF_FFFF_FFFF_8001);
    step();
    check("lh_pulse_off", ld_valid, 0);
    check("lh_hold", ld_data, 64'hFFFF_FFFF_FFFF_8001);
    run_load(1, 4'b0010, 64'h8000_0006, 3, 64'h8001_0000_0000_0000);
    check("lhu_data", ld_data, 64'h0000_0000_0000_8001);
    step();
    run_load(0, 4'b1000, 64'h8000_0000, 0, 64'h1122_3344_5566_7788);
    check("ld_skip_valid", ld_valid, 1);
    check("ld_data", ld_data, 64'h1122_3344_5566_7788);
    step();
    run_load(0, 4'b0001, 64'h8000_0005, 1, 64'h0000_9A00_0000_0000);
    check("lb_data", ld_data, 64'hFFFF_FFFF_FFFF_FF9A);
    step();
    run_load(1, 4'b0100, 64'h8000_0004, 2, 64'hDEAD_BEEF_0000_0000);
    check("lwu_data", ld_data, 64'h0000_0000_DEAD_BEEF);
    step();
    run_load(0, 4'b0100, 64'h8000_0004, 0, 64'hDEAD_BEEF_0000_0000);
    check("lw_data", ld_data, 64'hFFFF_FFFF_DEAD_BEEF);
    step();
    mem_rvalid = 1; mem_rdata = 64'h5555;
    step();
    mem_rvalid = 0;
    check("idle_rvalid_ign", ld_valid, 0);
    check("idle_rdata_hold", ld_data, 64'hFFFF_FFFF_DEAD_BEEF);
    issue(1, 0, 0, 4'b0000, 64'h8000_0000, 8'h00, 64'h0);
    check("drop_nosize", {ls_ready, mem_valid}, 2'b10);
    issue(0, 0, 0, 4'b0100, 64'h8000_0000, 8'h00, 64'h0);
    check("drop_nokind", {ls_ready, mem_valid}, 2'b10);
    mem_ready = 1;
    issue(1, 0, 0, 4'b1000, 64'h8000_0000, 8'h00, 64'h0);
    n = 0; saw = 0;
    while (!bus_err && n < 400) begin
      step();
      n++;
      if (ld_valid) saw = 1;
      if (n == 1) mem_ready = 0;
    end
    check("timeout_cycles", n, 256);
    check("timeout_err", bus_err, 1);
    check("timeout_noload", saw, 0);
    step();
    check("timeout_err_off", bus_err, 0);
    mem_ready = 1;
    issue(1, 0, 0, 4'b1000, 64'h8000_0000, 8'h00, 64'h0);
    step();
    mem_ready = 0;
    check("wait_busy", ls_ready, 0);
    reset = 1;
    step();
    reset = 0;
    check("rst_wait_idle", ls_ready, 1);
    check("rst_wait_pulses", {ld_valid, st_done, bus_err}, 0);
    check("rst_wait_ld_data", ld_data, 0);
    mem_rvalid = 1; mem_rdata = 64'h77;
    step();
    mem_rvalid = 0;
    check("late_resp_ign", {ld_valid, ld_data}, 0);
    issue(1, 0, 0, 4'b0100, 64'h8000_0002, 8'h0C, 64'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_err", bus_err, 1);
    check("mis_novalid", mem_valid, 0);
    step();
    check("mis_idle", {ls_ready, mem_valid}, 2'b10);
`else
    check("mis_issued", mem_valid, 1);
    check("mis_wmask", mem_wmask, 0);
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 64'h0;
    step();
    mem_ready = 0; mem_rvalid = 0;
    check("mis_noerr", {ld_valid, bus_err}, 2'b10);
`endif
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_core.md
LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 Parameter: WAIT_LIMIT, default 255, is the maximum number of cycles spent in WAIT before a bus error is declared.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  is a synchronous, active-high reset.
REQ-004 ls_valid  input  1  means an access request is present; it is sampled only in IDLE.
REQ-005 ls_ready  output  1  is high exactly when the state is IDLE.
REQ-006 Load, Loadu, Store  input  1 each  give the access kind: signed load, unsigned load, or store.
REQ-007 DWHB  input  4  gives the size one-hot: bit0 byte, bit1 half, bit2 word, bit3 double.
REQ-008 mask  input  8  is the byte-lane mask, pre-shifted by LS_addr[2:0].
REQ-009 LS_addr  input  64  is the effective byte address.
REQ-010 st_data  input  64  is the store data, right-aligned.
REQ-011 mem_valid/mem_ready  output/input  1  form the request handshake; the request is accepted when both are high on the same edge.
REQ-012 mem_addr  output  64  is LS_addr with bits [2:0] forced to 0.
REQ-013 mem_wen  output  1  is high for stores.
REQ-014 mem_wdata  output  64  is st_data << (8*LS_addr[2:0]).
REQ-015 mem_wmask  output  8  is the latched mask for stores and 0 for loads.
REQ-016 mem_rvalid/mem_rdata  input  1/64  carry the read response.
REQ-017 ld_valid  output  1  is a one-cycle pulse marking load completion.
REQ-018 ld_data  output  64  is the extended load result.
REQ-019 st_done  output  1  is a one-cycle pulse marking store completion.
REQ-020 bus_err  output  1  is a one-cycle pulse marking a timeout or misaligned access.

Function
REQ-021 The FSM SHALL have four states: IDLE, REQ, WAIT, RESP.
REQ-022 IDLE: when ls_valid is high and (Load|Loadu|Store) and DWHB != 0, latch all request fields and go to REQ; otherwise stay in IDLE (an invalid request is dropped silently).
REQ-023 REQ: hold mem_valid high with stable address, data and mask until mem_ready is high.
- Store accepted: go to RESP.
- Load accepted with mem_rvalid low: go to WAIT.
- Load accepted with mem_rvalid high in the same cycle: capture mem_rdata and go to RESP.
REQ-024 WAIT: on mem_rvalid, capture mem_rdata and go to RESP; the counter increments each WAIT cycle, and reaching WAIT_LIMIT goes to RESP with bus_err asserted.
REQ-025 RESP: lasts exactly one cycle, asserts ld_valid or st_done (unless bus_err), then returns to IDLE.
REQ-026 Minimum latency from request acceptance in IDLE to the ld_valid/st_done pulse SHALL be 2 cycles, with zero-wait memory.
REQ-027 Load extraction: shift captured data right by 8*addr[2:0], then select size with priority D>W>H>B.
- Loadu zero-extends to 64 bits.
- Load sign-extends from bit 7, 15 or 31.
REQ-028 Outside RESP, ld_valid, st_done and bus_err SHALL be 0; ld_data holds its last value.
REQ-029 mem_rvalid arriving in IDLE or RESP SHALL be ignored.
REQ-030 mem_valid SHALL be high only in REQ.

Reset
REQ-031 When reset is high, the next state SHALL be IDLE, regardless of the current state.
REQ-032 On reset, mem_valid, mem_wen, mem_wmask, ld_valid, st_done, bus_err, ld_data and the counter SHALL all be cleared to 0.
REQ-033 On reset mid-transaction, the outstanding memory access is abandoned, no completion pulse is issued, and later responses fall under REQ-029.

Configuration
REQ-034 Macro LSU_MISALIGN_CHECK_EN controls the misalignment check.
- Defined: in IDLE, a request whose address is not size-aligned (half: addr[0]; word: addr[1:0]; double: addr[2:0]) goes directly to RESP with bus_err=1 and no memory request.
- Undefined: no check is made; the access is issued with the supplied (possibly truncated) mask.

Verification
REQ-035 sb: LS_addr=0x80000003, st_data=0xAB, mem_ready=1 -> mem_addr=0x80000000, mem_wmask=0x08, mem_wdata=0xAB000000, st_done pulses 2 cycles after acceptance.
REQ-036 lh: addr=0x80000006, mem_rdata=0x8001_0000_0000_0000 after 3 wait cycles -> ld_data=0xFFFFFFFFFFFF8001.
REQ-037 lhu: same stimulus as REQ-036 -> ld_data=0x0000000000008001.
REQ-038 ld with mem_ready and mem_rvalid high in the same cycle, rdata=0x1122334455667788 -> ld_data=0x1122334455667788, REQ to RESP skipping WAIT.
REQ-039 Load with mem_rvalid held low -> bus_err pulses after WAIT_LIMIT cycles, no ld_valid; reset asserted in WAIT -> IDLE next cycle, no pulse.
REQ-040 lw at 0x80000002: with LSU_MISALIGN_CHECK_EN -> bus_err=1, mem_valid never high; without the macro -> request issued with mem_wmask=0.
